// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Build option: DMEM_ARB_RR_EN selects round-robin conflict resolution.
package dmem_arb_pkg;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_AUX  = 1'b1
   } owner_t;

   localparam logic [2:0] SZ_B  = 3'd0;
   localparam logic [2:0] SZ_H  = 3'd1;
   localparam logic [2:0] SZ_W  = 3'd2;
   localparam logic [2:0] SZ_BU = 3'd4;
   localparam logic [2:0] SZ_HU = 3'd5;

   localparam int unsigned DEFAULT_STARVE_LIMIT = 8;

endpackage

// File: rtl/dmem_arb_prio.sv
// Conflict-winner selection: starvation counter by default, round-robin flag
// when DMEM_ARB_RR_EN is defined.
module dmem_arb_prio
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   cReq,
   input  logic   aReq,
   input  logic   aGnt,
   output owner_t winner
);

`ifdef DMEM_ARB_RR_EN
   owner_t lastWin;

   always_ff @(posedge clk) begin
      if (rst)
         lastWin <= OWN_CORE;
      else if (cReq && aReq)
         lastWin <= aGnt ? OWN_AUX : OWN_CORE;
   end

   // The side that lost the previous conflict takes the next one.
   assign winner = (lastWin == OWN_CORE) ? OWN_AUX : OWN_CORE;
`else
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starveCnt;

   always_ff @(posedge clk) begin
      if (rst)
         starveCnt <= '0;
      else if (aGnt)
         starveCnt <= '0;
      else if (aReq && cReq && (starveCnt != LIMIT))
         starveCnt <= starveCnt + 4'd1;
   end

   assign winner = (starveCnt == LIMIT) ? OWN_AUX : OWN_CORE;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter (core + aux) with one-cycle read return.
// Build option: DMEM_ARB_RR_EN selects round-robin conflict resolution.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_ren,
   input  logic        c_wen,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [2:0]  c_size,
   output logic        c_stall,
   output logic [31:0] c_rdata,
   output logic        c_rvalid,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   input  logic [2:0]  a_size,
   output logic        a_gnt,
   output logic [31:0] a_rdata,
   output logic        a_rvalid,
   output logic        m_ren,
   output logic        m_wen,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [2:0]  m_size,
   input  logic [31:0] m_rdata
);

   logic   cReq;
   logic   cGnt;
   logic   aGnt;
   owner_t winner;
   logic   pendValid;
   owner_t pendOwner;

   assign cReq = c_ren | c_wen;
   assign cGnt = ~rst & cReq & (~a_req | (winner == OWN_CORE));
   assign aGnt = ~rst & a_req & (~cReq | (winner == OWN_AUX));

   assign a_gnt   = aGnt;
   assign c_stall = ~rst & cReq & ~cGnt;

   dmem_arb_prio #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_prio (
      .clk   (clk),
      .rst   (rst),
      .cReq  (cReq),
      .aReq  (a_req),
      .aGnt  (aGnt),
      .winner(winner)
   );

   // A core request with both enables set is a store.
   always_comb begin
      m_ren   = 1'b0;
      m_wen   = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_size  = '0;
      if (cGnt) begin
         m_ren   = c_ren & ~c_wen;
         m_wen   = c_wen;
         m_addr  = c_addr;
         m_wdata = c_wdata;
         m_size  = c_size;
      end else if (aGnt) begin
         m_ren   = ~a_we;
         m_wen   = a_we;
         m_addr  = a_addr;
         m_wdata = a_wdata;
         m_size  = a_size;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pendValid <= 1'b0;
         pendOwner <= OWN_CORE;
      end else begin
         pendValid <= m_ren;
         pendOwner <= aGnt ? OWN_AUX : OWN_CORE;
      end
   end

   assign c_rvalid = ~rst & pendValid & (pendOwner == OWN_CORE);
   assign a_rvalid = ~rst & pendValid & (pendOwner == OWN_AUX);
   assign c_rdata  = m_rdata;
   assign a_rdata  = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a cycle-level
// behavioural model of the arbitration and read-return rules.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int unsigned LIM = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c_ren = 1'b0, c_wen = 1'b0;
   logic [31:0] c_addr = '0, c_wdata = '0;
   logic [2:0]  c_size = '0;
   logic        c_stall, c_rvalid;
   logic [31:0] c_rdata;
   logic        a_req = 1'b0, a_we = 1'b0;
   logic [31:0] a_addr = '0, a_wdata = '0;
   logic [2:0]  a_size = '0;
   logic        a_gnt, a_rvalid;
   logic [31:0] a_rdata;
   logic        m_ren, m_wen;
   logic [31:0] m_addr, m_wdata;
   logic [2:0]  m_size;
   logic [31:0] m_rdata = '0;

   dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .c_ren(c_ren), .c_wen(c_wen), .c_addr(c_addr), .c_wdata(c_wdata), .c_size(c_size),
      .c_stall(c_stall), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_size(a_size),
      .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
      .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   int unsigned nChecks = 0;
   int unsigned nPass   = 0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs === exp) nPass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Reference model state: conflict history, pending read, loser-hold flags.
   int unsigned mStarve   = 0;
   bit          mLastAux  = 1'b0;
   bit          mPend     = 1'b0;
   bit          mPendAux  = 1'b0;
   bit          cHold     = 1'b0;
   bit          aHold     = 1'b0;
   bit          expCG, expAG;

   task automatic runCycle(input bit r,
                           input bit cr, input bit cw, input logic [31:0] ca,
                           input logic [31:0] cd, input logic [2:0] cs,
                           input bit ar, input bit aw, input logic [31:0] aa,
                           input logic [31:0] ad, input logic [2:0] as,
                           input logic [31:0] mr);
      bit cReq, auxWins, eRen, eWen, eStall, eCRv, eARv;
      @(negedge clk);
      rst = r; c_ren = cr; c_wen = cw; c_addr = ca; c_wdata = cd; c_size = cs;
      a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad; a_size = as; m_rdata = mr;
      #1;
      cReq = cr | cw;
`ifdef DMEM_ARB_RR_EN
      auxWins = !mLastAux;
`else
      auxWins = (mStarve == LIM);
`endif
      expCG  = !r && cReq && (!ar || !auxWins);
      expAG  = !r && ar && (!cReq || auxWins);
      eRen   = expCG ? (cr && !cw) : (expAG ? !aw : 1'b0);
      eWen   = expCG ? cw : (expAG ? aw : 1'b0);
      eStall = !r && cReq && !expCG;
      eCRv   = !r && mPend && !mPendAux;
      eARv   = !r && mPend && mPendAux;

      checkVal("m_ren",    32'(m_ren),    32'(eRen));
      checkVal("m_wen",    32'(m_wen),    32'(eWen));
      checkVal("c_stall",  32'(c_stall),  32'(eStall));
      checkVal("a_gnt",    32'(a_gnt),    32'(expAG));
      checkVal("c_rvalid", 32'(c_rvalid), 32'(eCRv));
      checkVal("a_rvalid", 32'(a_rvalid), 32'(eARv));
      checkVal("c_rdata",  c_rdata, mr);
      checkVal("a_rdata",  a_rdata, mr);
      if (expCG) begin
         checkVal("m_addr_c",  m_addr,  ca);
         checkVal("m_wdata_c", m_wdata, cd);
         checkVal("m_size_c",  32'(m_size), 32'(cs));
      end else if (expAG) begin
         checkVal("m_addr_a",  m_addr,  aa);
         checkVal("m_wdata_a", m_wdata, ad);
         checkVal("m_size_a",  32'(m_size), 32'(as));
      end

      if (r) begin
         mStarve = 0; mLastAux = 1'b0; mPend = 1'b0; mPendAux = 1'b0;
      end else begin
         mPend    = eRen;
         mPendAux = expAG;
`ifdef DMEM_ARB_RR_EN
         if (cReq && ar) mLastAux = expAG;
`else
         if (expAG) mStarve = 0;
         else if (ar && mStarve < LIM) mStarve++;
`endif
      end
      cHold = eStall;
      aHold = !r && ar && !expAG;
   endtask

   task automatic idle(input bit r, input logic [31:0] mr);
      runCycle(r, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, mr);
   endtask

   logic [2:0] sizes [5];

   initial begin
      sizes[0] = SZ_B; sizes[1] = SZ_H; sizes[2] = SZ_W; sizes[3] = SZ_BU; sizes[4] = SZ_HU;

      // Reset with requests present: everything held quiet.
      runCycle(1, 1, 0, 32'h10, 32'h1, SZ_W, 1, 0, 32'h20, 32'h2, SZ_W, 32'h0);
      runCycle(1, 1, 0, 32'h10, 32'h1, SZ_W, 1, 0, 32'h20, 32'h2, SZ_W, 32'h0);

      // Core-only load and its return.
      runCycle(0, 1, 0, 32'h100, 32'h0, SZ_W, 0, 0, '0, '0, '0, 32'h0);
      checkVal("ld_addr", m_addr, 32'h100);
      idle(0, 32'hDEADBEEF);
      checkVal("ld_rvalid", 32'(c_rvalid), 32'd1);
      checkVal("ld_rdata", c_rdata, 32'hDEADBEEF);

      // Aux-only write: no return.
      runCycle(0, 0, 0, '0, '0, '0, 1, 1, 32'h200, 32'h55, SZ_W, 32'h0);
      checkVal("aw_gnt", 32'(a_gnt), 32'd1);
      checkVal("aw_wdata", m_wdata, 32'h55);
      idle(0, 32'h12345678);
      checkVal("aw_norv", 32'({c_rvalid, a_rvalid}), 32'd0);

      // Continuous conflicting reads.
      for (int i = 0; i < 6; i++) begin
         runCycle(0, 1, 0, 32'h300, '0, SZ_W, 1, 0, 32'h400, '0, SZ_H, 32'hA000_0000 + 32'(i));
`ifdef DMEM_ARB_RR_EN
         checkVal("conf_agnt", 32'(a_gnt), 32'((i % 2) == 0));
`else
         checkVal("conf_agnt", 32'(a_gnt), 32'(i == 3));
`endif
      end
      idle(0, 32'hBBBB_0000);

      // Reset while an aux read is outstanding.
      idle(1, 32'h0);
      runCycle(0, 0, 0, '0, '0, '0, 1, 0, 32'h500, '0, SZ_B, 32'h0);
      checkVal("rr_agnt", 32'(a_gnt), 32'd1);
      idle(1, 32'hCAFE_0001);
      checkVal("rst_arv", 32'(a_rvalid), 32'd0);
      idle(0, 32'hCAFE_0002);
      checkVal("post_rst_arv", 32'(a_rvalid), 32'd0);

      // Core read+write with conflicting aux: treated as a store.
      runCycle(0, 1, 1, 32'h600, 32'h77, SZ_W, 1, 0, 32'h700, '0, SZ_W, 32'h0);
`ifndef DMEM_ARB_RR_EN
      checkVal("rw_wen", 32'({m_wen, m_ren}), 32'b10);
      checkVal("rw_stall_aux", 32'(a_gnt), 32'd0);
`endif
      for (int i = 0; i < 4; i++)
         runCycle(0, 1, 1, 32'h600, 32'h77, SZ_W, 1, 0, 32'h700, '0, SZ_W, 32'h1111_0000 + 32'(i));

      // Randomized traffic obeying the loser-holds-request rule.
      for (int n = 0; n < 600; n++) begin
         bit r, cr, cw, ar, aw;
         logic [31:0] ca, cd, aa, ad;
         logic [2:0] cs, as;
         r = ($urandom_range(0, 59) == 0);
         if (cHold) begin
            cr = c_ren; cw = c_wen; ca = c_addr; cd = c_wdata; cs = c_size;
         end else begin
            cr = ($urandom_range(0, 9) < 5); cw = ($urandom_range(0, 9) < 3);
            ca = $urandom; cd = $urandom; cs = sizes[$urandom_range(0, 4)];
         end
         if (aHold) begin
            ar = a_req; aw = a_we; aa = a_addr; ad = a_wdata; as = a_size;
         end else begin
            ar = ($urandom_range(0, 9) < 6); aw = $urandom_range(0, 1) == 1;
            aa = $urandom; ad = $urandom; as = sizes[$urandom_range(0, 4)];
         end
         runCycle(r, cr, cw, ca, cd, cs, ar, aw, aa, ad, as, $urandom);
      end
      idle(0, 32'h0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
